// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the PLL bring-up clock frequency meter.
// Default range is built from the nominal ref/PLL ratio so all instances agree.
package clk_meas_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_e;

  // Nominal setup: 1000 ref cycles per window, monitored clock at 1/10 of ref,
  // two edge pulses per monitored period -> 200 pulses per window, +/-10 slack.
  localparam int NOM_GATE_CYCLES = 1000;
  localparam int REF_PER_MON     = 10;
  localparam int NOM_COUNT       = 2 * NOM_GATE_CYCLES / REF_PER_MON;
  localparam int COUNT_TOL       = 10;
  localparam int EXP_MIN_DEF     = NOM_COUNT - COUNT_TOL;
  localparam int EXP_MAX_DEF     = NOM_COUNT + COUNT_TOL;

  function automatic int gate_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_meas_lock_tracker.sv
// Counts consecutive in-range windows and raises locked once enough are seen.
// Any out-of-range window or aborted measurement drops lock immediately.
module clk_meas_lock_tracker #(
  parameter int LOCK_WINDOWS = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_valid,
  input  logic i_in_range,
  input  logic i_abort,
  output logic o_locked
);

  localparam int LW_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [LW_W-1:0] LW_MAX = LW_W'(LOCK_WINDOWS);

  logic [LW_W-1:0] r_lock_cnt;
  logic [LW_W-1:0] w_lock_nxt;

  assign w_lock_nxt = (r_lock_cnt == LW_MAX) ? r_lock_cnt : r_lock_cnt + LW_W'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lock_cnt <= '0;
      o_locked   <= 1'b0;
    end else if (i_abort) begin
      r_lock_cnt <= '0;
      o_locked   <= 1'b0;
    end else if (i_valid) begin
      if (i_in_range) begin
        r_lock_cnt <= w_lock_nxt;
        o_locked   <= (w_lock_nxt == LW_MAX);
      end else begin
        r_lock_cnt <= '0;
        o_locked   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_edge_freq_meter.sv
// Gated edge-pulse counter: reports one count per GATE_CYCLES window, checks it
// against [EXP_MIN, EXP_MAX] and tracks lock over consecutive windows.
module clk_edge_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int GATE_CYCLES  = 1000,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = EXP_MIN_DEF,
  parameter int EXP_MAX      = EXP_MAX_DEF,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             enable,
  input  logic             edge_pulse,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             locked
);

  localparam int GATE_W = gate_cnt_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  RNG_LO    = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  RNG_HI    = CNT_W'(EXP_MAX);

  meas_state_e       r_state;
  meas_state_e       w_state_d;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;

  logic [CNT_W-1:0]  w_edge_nxt;
  logic              w_sat_nxt;
  logic              w_terminal;
  logic              w_report;
  logic              w_abort;
  logic              w_in_range_d;

  // Overflow means a pulse actually arrived while the counter was already full,
  // so a window that lands exactly on CNT_MAX is not flagged.
  assign w_edge_nxt   = (edge_pulse && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + CNT_W'(1)
                                                                : r_edge_cnt;
  assign w_sat_nxt    = r_sat | (edge_pulse & (r_edge_cnt == CNT_MAX));
  assign w_terminal   = (r_state == MEASURE) && (r_gate_cnt == GATE_LAST);
  assign w_report     = w_terminal && enable;
  assign w_abort      = (r_state == MEASURE) && !enable;
  assign w_in_range_d = (w_edge_nxt >= RNG_LO) && (w_edge_nxt <= RNG_HI) && !w_sat_nxt;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_d = MEASURE;
      MEASURE: if (!enable) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      meas_valid <= 1'b0;
      if (r_state != MEASURE || w_abort) begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end else if (w_report) begin
        // Publish and restart in the same edge so windows tile with no gap.
        meas_count <= w_edge_nxt;
        meas_valid <= 1'b1;
        in_range   <= w_in_range_d;
        overflow   <= w_sat_nxt;
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end else begin
        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        r_edge_cnt <= w_edge_nxt;
        r_sat      <= w_sat_nxt;
      end
    end
  end

  clk_meas_lock_tracker #(
    .LOCK_WINDOWS(LOCK_WINDOWS)
  ) u_lock (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_valid   (w_report),
    .i_in_range(w_in_range_d),
    .i_abort   (w_abort),
    .o_locked  (locked)
  );

endmodule

// File: tb/tb_clk_edge_freq_meter.sv
// Directed bench for clk_edge_freq_meter with a 10-cycle gate; a second
// instance with a 3-bit counter shares the stimulus to exercise saturation.
module tb_clk_edge_freq_meter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       enable;
  logic       edge_pulse;
  logic [3:0] meas_count;
  logic       meas_valid, in_range, overflow, locked;
  logic [2:0] meas_count2;
  logic       meas_valid2, in_range2, overflow2, locked2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  clk_edge_freq_meter #(
    .GATE_CYCLES(10), .CNT_W(4), .EXP_MIN(4), .EXP_MAX(6), .LOCK_WINDOWS(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .edge_pulse(edge_pulse),
    .meas_count(meas_count), .meas_valid(meas_valid), .in_range(in_range),
    .overflow(overflow), .locked(locked)
  );

  clk_edge_freq_meter #(
    .GATE_CYCLES(10), .CNT_W(3), .EXP_MIN(4), .EXP_MAX(6), .LOCK_WINDOWS(2)
  ) dut_w3 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .edge_pulse(edge_pulse),
    .meas_count(meas_count2), .meas_valid(meas_valid2), .in_range(in_range2),
    .overflow(overflow2), .locked(locked2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic ep);
    enable     = en;
    edge_pulse = ep;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cnt"},  32'(meas_count), 32'd0);
    check({tag, "_vld"},  32'(meas_valid), 32'd0);
    check({tag, "_rng"},  32'(in_range),   32'd0);
    check({tag, "_ovf"},  32'(overflow),   32'd0);
    check({tag, "_lock"}, 32'(locked),     32'd0);
  endtask

  // One full gate window starting in MEASURE; pat[i] drives gate cycle i.
  task automatic window(input string tag, input logic [9:0] pat, input int exp_cnt,
                        input logic exp_rng, input logic exp_lock);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, pat[i]);
      check({tag, "_vld"}, 32'(meas_valid), 32'((i == 9)));
    end
    check({tag, "_cnt"},  32'(meas_count), 32'(exp_cnt));
    check({tag, "_rng"},  32'(in_range),   32'(exp_rng));
    check({tag, "_ovf"},  32'(overflow),   32'd0);
    check({tag, "_lock"}, 32'(locked),     32'(exp_lock));
  endtask

  localparam logic [9:0] PAT_ALT  = 10'b0101010101;
  localparam logic [9:0] PAT_TERM = 10'b1001010101;
  localparam logic [9:0] PAT_ALL  = 10'b1111111111;

  initial begin
    RST_N      = 1'b0;
    enable     = 1'b0;
    edge_pulse = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Scenario 1: steady in-range windows, lock on the second
    cyc(1'b1, 1'b0);
    check("start_vld", 32'(meas_valid), 32'd0);
    window("s1w1", PAT_ALT, 5, 1'b1, 1'b0);
    check("s1w1_w3cnt", 32'(meas_count2), 32'd5);
    window("s1w2", PAT_ALT, 5, 1'b1, 1'b1);

    // Scenario 2: terminal-cycle pulse is counted
    window("s2", PAT_TERM, 5, 1'b1, 1'b1);

    // Scenario 3/4: out-of-range window drops lock; narrow counter saturates
    window("s3bad", PAT_ALL, 10, 1'b0, 1'b0);
    check("s4_cnt",  32'(meas_count2), 32'd7);
    check("s4_ovf",  32'(overflow2),   32'd1);
    check("s4_rng",  32'(in_range2),   32'd0);
    check("s4_vld",  32'(meas_valid2), 32'd1);
    check("s4_lock", 32'(locked2),     32'd0);
    window("s3re1", PAT_ALT, 5, 1'b1, 1'b0);
    window("s3re2", PAT_ALT, 5, 1'b1, 1'b1);

    // Scenario 5: abort at gate cycle 6, then re-enable
    for (int i = 0; i < 6; i++) cyc(1'b1, PAT_ALL[i]);
    cyc(1'b0, 1'b1);
    check("s5_vld",  32'(meas_valid), 32'd0);
    check("s5_lock", 32'(locked),     32'd0);
    check("s5_cnt",  32'(meas_count), 32'd5);
    check("s5_rng",  32'(in_range),   32'd1);
    cyc(1'b0, 1'b1);
    check("s5_idle_vld", 32'(meas_valid), 32'd0);
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b1, (k == 1) ? 1'b1 : PAT_ALT[k-2]);
      check("s5_re_vld", 32'(meas_valid), 32'((k == 11)));
    end
    check("s5_re_cnt",  32'(meas_count), 32'd5);
    check("s5_re_lock", 32'(locked),     32'd0);
    window("s5w2", PAT_ALT, 5, 1'b1, 1'b1);

    // Scenario 6: asynchronous reset mid-window
    for (int i = 0; i < 4; i++) cyc(1'b1, PAT_ALT[i]);
    #2;
    RST_N = 1'b0;
    #1;
    check_outputs_zero("s6_async");
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(1'b1, 1'b0);
    check("s6_start_vld", 32'(meas_valid), 32'd0);
    window("s6w1", PAT_ALT, 5, 1'b1, 1'b0);
    window("s6w2", PAT_ALT, 5, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
